lc3_mmio_console: RTL
=====================

LC3_MMIO_CONSOLE -- requirements
Module: lc3_mmio_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning display FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port address, input, 16, CPU data-bus address (the same bus that drives ram).
REQ-005 SHALL have port word_in, input, 16, CPU write data.
REQ-006 SHALL have port WrEn, input, 1, CPU write strobe, qualified by address hit.
REQ-007 SHALL have port RdEn, input, 1, CPU read strobe, qualified by address hit; used only for read side effects.
REQ-008 SHALL have port word_out, output, 16, read data for the addressed register.
REQ-009 SHALL have port hit, output, 1, high when address is in xFE00..xFE06 (even addresses only), so the top level selects word_out over ram.
REQ-010 SHALL have ports kbd_valid (input, 1), kbd_data (input, 8) and kbd_ready (output, 1), forming the keyboard receive handshake.
REQ-011 SHALL have ports disp_valid (output, 1), disp_data (output, 8) and disp_ready (input, 1), forming the display transmit handshake.
REQ-012 SHALL have port irq, output, 1, keyboard interrupt request (see Configuration).

Function
REQ-013 SHALL decode xFE00 KBSR, xFE02 KBDR, xFE04 DSR and xFE06 DDR; any other address drives hit=0 and word_out=0.
REQ-014 SHALL make reads combinational from registered state: word_out is valid in the same cycle as address.
REQ-015 KBSR read SHALL return {kbd_full, kbd_ie, 14'b0}; a KBSR write SHALL update kbd_ie from word_in[14] only.
REQ-016 KBDR read SHALL return {8'b0, kbd_byte}; RdEn on KBDR SHALL clear kbd_full at the next edge.
REQ-017 kbd_ready SHALL equal !kbd_full; a transfer occurs when kbd_valid&&kbd_ready; kbd_byte<=kbd_data and kbd_full<=1 at that edge.
REQ-018 A KBDR read and a keyboard transfer SHALL never coincide, because kbd_ready=0 whenever kbd_full=1.
REQ-019 DSR read SHALL return {!fifo_full, 14'b0, ovf}; a DSR write with word_in[0]=1 SHALL clear ovf.
REQ-020 A DDR write SHALL push word_in[7:0] into the FIFO; a push when full SHALL be dropped and SHALL set ovf.
REQ-021 When the FIFO is full and a pop occurs in the same cycle as a push, the push SHALL be accepted and ovf SHALL remain unchanged.
REQ-022 disp_valid SHALL equal !fifo_empty, and disp_data SHALL equal the head entry; a pop occurs when disp_valid&&disp_ready.
REQ-023 A push to an empty FIFO SHALL make disp_valid high one cycle later (write-to-output latency 1).
REQ-024 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full is signalled by MSBs differing while the low bits are equal.
REQ-025 The FIFO SHALL preserve order; occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-026 Reset SHALL clear kbd_full, kbd_ie, kbd_byte, ovf and both FIFO pointers, giving kbd_ready=1, disp_valid=0 and irq=0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and any latched key without emitting a handshake.

Configuration
REQ-028 With CONSOLE_IRQ_EN defined, irq SHALL be registered as kbd_full&&kbd_ie.
REQ-029 Without CONSOLE_IRQ_EN, irq SHALL be tied 0, kbd_ie SHALL read 0 and KBSR writes SHALL be ignored.

Structure
REQ-030 Package lc3_mmio_pkg SHALL hold the four register addresses and the KBSR/DSR bit indices as constants.
REQ-031 The FIFO SHALL be a sub-module console_fifo (parameter DEPTH, width 8, push/pop/full/empty).

Verification
REQ-032 Reset check: after reset -> kbd_ready=1, disp_valid=0, DSR read=x8000, KBSR read=x0000.
REQ-033 Keyboard: kbd_valid with kbd_data=x41 -> KBSR=x8000 and kbd_ready=0; KBDR read -> x0041, and KBSR=x0000 on the next cycle.
REQ-034 Display: write xFE06 with x0048 while disp_ready=0 -> disp_valid=1 with data x48 one cycle later; on raising disp_ready -> one pop, then disp_valid=0.
REQ-035 Overflow: 9 DDR writes with disp_ready=0 and FIFO_DEPTH=8 -> 9th write dropped and DSR=x0001; draining yields exactly 8 bytes in order; DSR write x0001 -> ovf cleared.
REQ-036 Full with simultaneous push and pop: FIFO full, DDR write and disp_ready=1 in the same cycle -> occupancy stays 8 and ovf=0.
REQ-037 IRQ (CONSOLE_IRQ_EN defined): write KBSR x4000, then a key arrives -> irq=1 one cycle after the transfer; KBDR read -> irq=0.

Source files
------------

// File: rtl/lc3_mmio_pkg.sv
// LC-3 console register map and status bit positions.
// Shared by the console top and its bench.
package lc3_mmio_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int KBSR_FULL_BIT = 15;
    localparam int KBSR_IE_BIT   = 14;
    localparam int DSR_RDY_BIT   = 15;
    localparam int DSR_OVF_BIT   = 0;

endpackage

// File: rtl/console_fifo.sv
// Display byte FIFO with wrap-bit pointers.
// A push while full is taken only if a pop frees a slot in the same cycle.
module console_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lc3_mmio_console.sv
// LC-3 memory-mapped keyboard/display console.
// Define CONSOLE_IRQ_EN to enable the KBSR interrupt-enable bit and irq.
module lc3_mmio_console
    import lc3_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] word_in,
    input  logic        WrEn,
    input  logic        RdEn,
    output logic [15:0] word_out,
    output logic        hit,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        irq
);

    logic       kbd_full;
    logic       kbd_full_n;
    logic [7:0] kbd_byte;
    logic       kbd_ie;
    logic       ovf;
    logic       fifo_full;
    logic       fifo_empty;
    logic       kbd_xfer;
    logic       kbdr_rd;
    logic       ddr_wr;
    logic       dsr_wr;
    logic       disp_pop;
    logic       unused_bits;

    assign kbdr_rd   = RdEn && (address == KBDR_ADDR);
    assign ddr_wr    = WrEn && (address == DDR_ADDR);
    assign dsr_wr    = WrEn && (address == DSR_ADDR);
    assign kbd_ready = !kbd_full;
    assign kbd_xfer  = kbd_valid && kbd_ready;
    assign disp_valid = !fifo_empty;
    assign disp_pop   = disp_valid && disp_ready;
    assign unused_bits = ^word_in[15:8];

    always_comb begin
        kbd_full_n = kbd_full;
        if (kbdr_rd)  kbd_full_n = 1'b0;
        if (kbd_xfer) kbd_full_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_full <= 1'b0;
            kbd_byte <= 8'h00;
            ovf      <= 1'b0;
        end else begin
            kbd_full <= kbd_full_n;
            if (kbd_xfer) kbd_byte <= kbd_data;
            if (dsr_wr && word_in[DSR_OVF_BIT]) ovf <= 1'b0;
            if (ddr_wr && fifo_full && !disp_pop) ovf <= 1'b1;
        end
    end

`ifdef CONSOLE_IRQ_EN
    logic kbd_ie_n;
    logic kbsr_wr;

    assign kbsr_wr = WrEn && (address == KBSR_ADDR);

    always_comb begin
        kbd_ie_n = kbd_ie;
        if (kbsr_wr) kbd_ie_n = word_in[KBSR_IE_BIT];
    end

    // Registered from next-state so irq lines up with kbd_full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_ie <= 1'b0;
            irq    <= 1'b0;
        end else begin
            kbd_ie <= kbd_ie_n;
            irq    <= kbd_full_n && kbd_ie_n;
        end
    end
`else
    assign kbd_ie = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        hit      = 1'b1;
        word_out = 16'h0000;
        case (address)
            KBSR_ADDR: begin
                word_out[KBSR_FULL_BIT] = kbd_full;
                word_out[KBSR_IE_BIT]   = kbd_ie;
            end
            KBDR_ADDR: word_out[7:0] = kbd_byte;
            DSR_ADDR: begin
                word_out[DSR_RDY_BIT] = !fifo_full;
                word_out[DSR_OVF_BIT] = ovf;
            end
            DDR_ADDR: word_out = 16'h0000;
            default:  hit = 1'b0;
        endcase
    end

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ddr_wr),
        .pop   (disp_pop),
        .din   (word_in[7:0]),
        .dout  (disp_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
